text_writer: RTL and testbench

- Writer end of the text-mode display path: consumes an ASCII byte stream and writes character codes into the dual-port screen RAM that the display pipeline reads.
- Maintains the cursor and performs control-code handling (CR, LF, BS, FF).
- Scrolls by rotating a top-row pointer; no memory copy is performed.
- Sits between the host/UART byte source and the RAM write port. scroll_row feeds the display row-address adder.

---
 rtl/text_writer.sv | 172 +++++++++++++++++
 tb/tb_text_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// rtl/text_writer.sv - ASCII byte stream to text-mode screen RAM writer with cursor, control codes and rotating scroll
module text_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       wr_en,
    output logic [6:0] wr_col,
    output logic [4:0] wr_row,
    output logic [7:0] wr_char,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic [4:0] scroll_row
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        CLEAR_LINE
    } state_t;

    state_t     state, state_n;
    logic [6:0] clr_col, clr_col_n;
    logic [4:0] clr_row, clr_row_n;
    logic       in_ready_n, wr_en_n;
    logic [6:0] wr_col_n, cursor_col_n;
    logic [4:0] wr_row_n, cursor_row_n, scroll_row_n;
    logic [7:0] wr_char_n;
    logic       do_lf;
    logic       printable;
    logic [5:0] row_sum;
    logic [4:0] phys_row;

    // Logical-to-physical row mapping; explicit wrap so ROWS need not be a power of two.
    assign row_sum   = {1'b0, scroll_row} + {1'b0, cursor_row};
    assign phys_row  = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : row_sum[4:0];
    assign printable = (in_char >= 8'h20) && (in_char != 8'h7F);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= CLEAR_ALL;
            clr_col    <= '0;
            clr_row    <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_col     <= '0;
            wr_row     <= '0;
            wr_char    <= 8'h20;
            cursor_col <= '0;
            cursor_row <= '0;
            scroll_row <= '0;
        end else begin
            state      <= state_n;
            clr_col    <= clr_col_n;
            clr_row    <= clr_row_n;
            in_ready   <= in_ready_n;
            wr_en      <= wr_en_n;
            wr_col     <= wr_col_n;
            wr_row     <= wr_row_n;
            wr_char    <= wr_char_n;
            cursor_col <= cursor_col_n;
            cursor_row <= cursor_row_n;
            scroll_row <= scroll_row_n;
        end
    end

    always_comb begin
        state_n      = state;
        clr_col_n    = clr_col;
        clr_row_n    = clr_row;
        in_ready_n   = 1'b0;
        wr_en_n      = 1'b0;
        wr_col_n     = wr_col;
        wr_row_n     = wr_row;
        wr_char_n    = wr_char;
        cursor_col_n = cursor_col;
        cursor_row_n = cursor_row;
        scroll_row_n = scroll_row;
        do_lf        = 1'b0;

        case (state)
            CLEAR_ALL: begin
                wr_en_n   = 1'b1;
                wr_col_n  = clr_col;
                wr_row_n  = clr_row;
                wr_char_n = 8'h20;
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_n = '0;
                        state_n   = IDLE;
                    end else begin
                        clr_row_n = clr_row + 5'd1;
                    end
                end else begin
                    clr_col_n = clr_col + 7'd1;
                end
            end

            IDLE: begin
                in_ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    if (printable) begin
                        wr_en_n   = 1'b1;
                        wr_col_n  = cursor_col;
                        wr_row_n  = phys_row;
                        wr_char_n = in_char;
                        if (cursor_col == LAST_COL) begin
                            cursor_col_n = '0;
                            do_lf        = 1'b1;
                        end else begin
                            cursor_col_n = cursor_col + 7'd1;
                        end
                    end else begin
                        case (in_char)
                            8'h0D: cursor_col_n = '0;
                            8'h0A: do_lf = 1'b1;
                            8'h08: if (cursor_col != '0) cursor_col_n = cursor_col - 7'd1;
                            8'h0C: begin
                                cursor_col_n = '0;
                                cursor_row_n = '0;
                                scroll_row_n = '0;
                                clr_col_n    = '0;
                                clr_row_n    = '0;
                                in_ready_n   = 1'b0;
                                state_n      = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // At the bottom row, rotate the top pointer and blank the row that wrapped around.
                    if (do_lf) begin
                        if (cursor_row != LAST_ROW) begin
                            cursor_row_n = cursor_row + 5'd1;
                        end else begin
                            scroll_row_n = (scroll_row == LAST_ROW) ? 5'd0 : scroll_row + 5'd1;
                            clr_row_n    = scroll_row;
                            clr_col_n    = '0;
                            in_ready_n   = 1'b0;
                            state_n      = CLEAR_LINE;
                        end
                    end
                end
            end

            CLEAR_LINE: begin
                wr_en_n   = 1'b1;
                wr_col_n  = clr_col;
                wr_row_n  = clr_row;
                wr_char_n = 8'h20;
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_col_n = clr_col + 7'd1;
                end
            end

            default: state_n = CLEAR_ALL;
        endcase
    end

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - directed self-checking bench for text_writer
module tb_text_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       wr_en;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_char;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic [4:0] scroll_row;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    text_writer #(.COLS(80), .ROWS(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .scroll_row (scroll_row)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_char  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int k = 0;
        while (in_ready !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        ok = (in_ready === 1'b1);
    endtask

    task automatic expect_clear_all(input string tag);
        int bad = 0;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (wr_en !== 1'b1 || wr_row !== 5'(r) || wr_col !== 7'(c) ||
                    wr_char !== 8'h20 || in_ready !== 1'b0)
                    bad++;
            end
        end
        check({tag, "_clear_all_bad_cells"}, bad, 0);
        @(negedge clk);
        check({tag, "_ready_after"}, int'(in_ready), 1);
        check({tag, "_wr_en_after"}, int'(wr_en), 0);
    endtask

    task automatic expect_clear_line(input string tag, input int row);
        int bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || wr_row !== 5'(row) || wr_col !== 7'(c) ||
                wr_char !== 8'h20 || in_ready !== 1'b0)
                bad++;
        end
        check({tag, "_clear_line_bad_cells"}, bad, 0);
        @(negedge clk);
        check({tag, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int  bad;
        int  timeouts;
        bit  ok;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_col", int'(wr_col), 0);
        check("rst_wr_row", int'(wr_row), 0);
        check("rst_wr_char", int'(wr_char), 32);
        check("rst_cursor_col", int'(cursor_col), 0);
        check("rst_cursor_row", int'(cursor_row), 0);
        check("rst_scroll", int'(scroll_row), 0);

        reset_n = 1'b1;
        expect_clear_all("boot");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en !== 1'b0) bad++;
        end
        check("idle_no_writes", bad, 0);

        // Back-to-back 'A','B'
        in_valid = 1'b1;
        in_char  = 8'h41;
        @(negedge clk);
        check("a_wr_en", int'(wr_en), 1);
        check("a_addr", int'({wr_row, wr_col}), 0);
        check("a_char", int'(wr_char), 8'h41);
        in_char = 8'h42;
        @(negedge clk);
        in_valid = 1'b0;
        check("b_wr_en", int'(wr_en), 1);
        check("b_col", int'(wr_col), 1);
        check("b_char", int'(wr_char), 8'h42);
        check("ab_cursor_col", int'(cursor_col), 2);
        check("ab_cursor_row", int'(cursor_row), 0);
        @(negedge clk);
        check("ab_idle_wr_en", int'(wr_en), 0);

        put(8'h08);
        check("bs_cursor_col", int'(cursor_col), 1);
        check("bs_no_write", int'(wr_en), 0);
        put(8'h07);
        check("ignored_byte_col", int'(cursor_col), 1);
        check("ignored_byte_no_write", int'(wr_en), 0);
        put(8'h0D);
        check("cr_cursor_col", int'(cursor_col), 0);

        // Full line of 'x' wraps to next row without scrolling
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            put(8'h78);
            if (wr_en !== 1'b1 || wr_col !== 7'(i) || wr_row !== 5'd0 || wr_char !== 8'h78) bad++;
        end
        check("line_x_bad_writes", bad, 0);
        check("line_x_cursor_row", int'(cursor_row), 1);
        check("line_x_cursor_col", int'(cursor_col), 0);
        check("line_x_scroll", int'(scroll_row), 0);
        check("line_x_ready", int'(in_ready), 1);
        put(8'h0D);
        put(8'h08);
        check("cr_bs_cursor_row", int'(cursor_row), 1);
        check("cr_bs_cursor_col", int'(cursor_col), 0);

        // Move to (23,5) and scroll with LF
        repeat (22) put(8'h0A);
        repeat (5) put(8'h79);
        check("pos_cursor_row", int'(cursor_row), 23);
        check("pos_cursor_col", int'(cursor_col), 5);
        put(8'h0A);
        check("lf_scroll", int'(scroll_row), 1);
        check("lf_cursor_row", int'(cursor_row), 23);
        check("lf_cursor_col", int'(cursor_col), 5);
        check("lf_ready_low", int'(in_ready), 0);
        check("lf_no_char_write", int'(wr_en), 0);
        expect_clear_line("lf", 0);
        put(8'h5A);
        check("z_wr_en", int'(wr_en), 1);
        check("z_row", int'(wr_row), 0);
        check("z_col", int'(wr_col), 5);
        check("z_char", int'(wr_char), 8'h5A);

        // Scroll up to scroll_row=23, then fill to col 79
        timeouts = 0;
        repeat (22) begin
            put(8'h0A);
            wait_ready(ok);
            if (!ok) timeouts++;
        end
        check("scroll_wait_timeouts", timeouts, 0);
        check("scroll_to_23", int'(scroll_row), 23);
        repeat (73) put(8'h71);
        check("pre_q_cursor_col", int'(cursor_col), 79);
        check("pre_q_cursor_row", int'(cursor_row), 23);
        put(8'h51);
        check("q_wr_en", int'(wr_en), 1);
        check("q_row", int'(wr_row), 22);
        check("q_col", int'(wr_col), 79);
        check("q_char", int'(wr_char), 8'h51);
        check("q_scroll_wrap", int'(scroll_row), 0);
        check("q_cursor_row", int'(cursor_row), 23);
        check("q_cursor_col", int'(cursor_col), 0);
        check("q_ready_low", int'(in_ready), 0);
        expect_clear_line("q", 23);

        // Form feed mid-stream
        put(8'h61);
        put(8'h0C);
        check("ff_cursor_col", int'(cursor_col), 0);
        check("ff_cursor_row", int'(cursor_row), 0);
        check("ff_scroll", int'(scroll_row), 0);
        check("ff_no_write", int'(wr_en), 0);
        check("ff_ready_low", int'(in_ready), 0);
        expect_clear_all("ff");

        // Reset in the middle of a full clear restarts from (0,0)
        put(8'h0C);
        repeat (499) @(negedge clk);
        check("mid_clear_row", int'(wr_row), 6);
        check("mid_clear_col", int'(wr_col), 18);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_wr_en", int'(wr_en), 0);
        check("mid_rst_wr_char", int'(wr_char), 32);
        check("mid_rst_ready", int'(in_ready), 0);
        reset_n = 1'b1;
        expect_clear_all("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
